// File: rtl/regfile_dpram_ctrl.sv
// Register-file sequencer for two side-by-side DP16KD RAMs: zero-fills after reset,
// then arbitrates paired rs1/rs2 reads and single rd writes across the two RAM ports.
module regfile_dpram_ctrl #(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned IDX_W    = 5,
  parameter int unsigned ADDR_LSB = 4
) (
  input  logic              Clock,
  input  logic              Reset,
  output logic              init_done,
  input  logic              rd_valid,
  output logic              rd_ready,
  input  logic [IDX_W-1:0]  rs1_idx,
  input  logic [IDX_W-1:0]  rs2_idx,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rs1_data,
  output logic [DATA_W-1:0] rs2_data,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [IDX_W-1:0]  wr_idx,
  input  logic [DATA_W-1:0] wr_data,
  output logic [13:0]       ram_addr_a,
  output logic [13:0]       ram_addr_b,
  output logic [DATA_W-1:0] ram_din_a,
  output logic [DATA_W-1:0] ram_din_b,
  output logic              ram_we_a,
  output logic              ram_we_b,
  output logic              ram_ce_a,
  output logic              ram_ce_b,
  input  logic [DATA_W-1:0] ram_qa,
  input  logic [DATA_W-1:0] ram_qb
);

  localparam int unsigned RAM_AW      = 14;
  localparam int unsigned NUM_REGS    = 2 ** IDX_W;
  localparam int unsigned CNT_W       = IDX_W - 1;
  localparam int unsigned IDX_FIELD_W = RAM_AW - ADDR_LSB;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NUM_REGS / 2 - 1);

  typedef enum logic {ST_INIT, ST_RUN} state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              init_done_q, init_done_d;
  logic              read_prio_q, read_prio_d;
  logic              rd_pend_q, rd_pend_d;
  logic [IDX_W-1:0]  rs1_idx_q, rs1_idx_d;
  logic [IDX_W-1:0]  rs2_idx_q, rs2_idx_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0] rs1_data_q, rs1_data_d;
  logic [DATA_W-1:0] rs2_data_q, rs2_data_d;
  logic              wr_nz, rd_fire, wr_fire;

  // Index lands at addr[13:ADDR_LSB]; low bits carry the two byte enables.
  function automatic logic [RAM_AW-1:0] idx_addr(input logic [IDX_W-1:0] idx);
    idx_addr = {IDX_FIELD_W'(idx), ADDR_LSB'(2'b11)};
  endfunction

  assign init_done = init_done_q;
  assign rsp_valid = rsp_valid_q;
  assign rs1_data  = rs1_data_q;
  assign rs2_data  = rs2_data_q;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    init_done_d = init_done_q;
    read_prio_d = read_prio_q;
    rd_pend_d   = 1'b0;
    rs1_idx_d   = rs1_idx_q;
    rs2_idx_d   = rs2_idx_q;
    rsp_valid_d = rd_pend_q;
    rs1_data_d  = rs1_data_q;
    rs2_data_d  = rs2_data_q;
    rd_ready    = 1'b0;
    wr_ready    = 1'b0;
    wr_nz       = (wr_idx != '0);
    rd_fire     = 1'b0;
    wr_fire     = 1'b0;
    ram_addr_a  = '0;
    ram_addr_b  = '0;
    ram_din_a   = '0;
    ram_din_b   = '0;
    ram_we_a    = 1'b0;
    ram_we_b    = 1'b0;
    ram_ce_a    = 1'b0;
    ram_ce_b    = 1'b0;

    // RAM data for the read issued last cycle is valid now; x0 always reads zero.
    if (rd_pend_q) begin
      rs1_data_d = (rs1_idx_q == '0) ? '0 : ram_qa;
      rs2_data_d = (rs2_idx_q == '0) ? '0 : ram_qb;
    end

    if (!Reset) begin
      unique case (state_q)
        ST_INIT: begin
          ram_addr_a = idx_addr({cnt_q, 1'b0});
          ram_addr_b = idx_addr({cnt_q, 1'b1});
          ram_we_a   = 1'b1;
          ram_we_b   = 1'b1;
          ram_ce_a   = 1'b1;
          ram_ce_b   = 1'b1;
          cnt_d      = CNT_W'(cnt_q + 1'b1);
          if (cnt_q == CNT_LAST) begin
            state_d     = ST_RUN;
            init_done_d = 1'b1;
            cnt_d       = '0;
          end
        end
        ST_RUN: begin
          // Writes win unless a read has already been held off once.
          rd_ready = !(wr_valid && wr_nz) || read_prio_q;
          wr_ready = !(rd_valid && read_prio_q);
          rd_fire  = rd_valid && rd_ready;
          wr_fire  = wr_valid && wr_ready;
          if (rd_fire) begin
            ram_addr_a  = idx_addr(rs1_idx);
            ram_addr_b  = idx_addr(rs2_idx);
            ram_ce_a    = 1'b1;
            ram_ce_b    = 1'b1;
            rd_pend_d   = 1'b1;
            rs1_idx_d   = rs1_idx;
            rs2_idx_d   = rs2_idx;
            read_prio_d = 1'b0;
          end else if (wr_fire && wr_nz) begin
            ram_addr_a = idx_addr(wr_idx);
            ram_din_a  = wr_data;
            ram_we_a   = 1'b1;
            ram_ce_a   = 1'b1;
            if (rd_valid) read_prio_d = 1'b1;
          end
        end
      endcase
    end
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q     <= ST_INIT;
      cnt_q       <= '0;
      init_done_q <= 1'b0;
      read_prio_q <= 1'b0;
      rd_pend_q   <= 1'b0;
      rs1_idx_q   <= '0;
      rs2_idx_q   <= '0;
      rsp_valid_q <= 1'b0;
      rs1_data_q  <= '0;
      rs2_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      init_done_q <= init_done_d;
      read_prio_q <= read_prio_d;
      rd_pend_q   <= rd_pend_d;
      rs1_idx_q   <= rs1_idx_d;
      rs2_idx_q   <= rs2_idx_d;
      rsp_valid_q <= rsp_valid_d;
      rs1_data_q  <= rs1_data_d;
      rs2_data_q  <= rs2_data_d;
    end
  end

endmodule

// File: tb/tb_regfile_dpram_ctrl.sv
// Bench for regfile_dpram_ctrl: behavioural DP16KD pair, register model and response scoreboard.
module tb_regfile_dpram_ctrl;

  logic        Clock = 1'b0;
  logic        Reset;
  logic        init_done;
  logic        rd_valid, rd_ready;
  logic [4:0]  rs1_idx, rs2_idx;
  logic        rsp_valid;
  logic [31:0] rs1_data, rs2_data;
  logic        wr_valid, wr_ready;
  logic [4:0]  wr_idx;
  logic [31:0] wr_data;
  logic [13:0] ram_addr_a, ram_addr_b;
  logic [31:0] ram_din_a, ram_din_b;
  logic        ram_we_a, ram_we_b, ram_ce_a, ram_ce_b;
  logic [31:0] ram_qa, ram_qb;

  regfile_dpram_ctrl dut (
    .Clock(Clock), .Reset(Reset), .init_done(init_done),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rs1_idx(rs1_idx), .rs2_idx(rs2_idx),
    .rsp_valid(rsp_valid), .rs1_data(rs1_data), .rs2_data(rs2_data),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_idx(wr_idx), .wr_data(wr_data),
    .ram_addr_a(ram_addr_a), .ram_addr_b(ram_addr_b),
    .ram_din_a(ram_din_a), .ram_din_b(ram_din_b),
    .ram_we_a(ram_we_a), .ram_we_b(ram_we_b),
    .ram_ce_a(ram_ce_a), .ram_ce_b(ram_ce_b),
    .ram_qa(ram_qa), .ram_qb(ram_qb)
  );

  always #5 Clock = ~Clock;

  // Two-port RAM, NOREG output, write-through on write; starts full of junk.
  logic [31:0] mem [1024];
  bit          mem_filled = 1'b0;
  logic        poke_en = 1'b0;
  logic [31:0] poke_val = '0;
  always @(posedge Clock) begin
    if (!mem_filled) begin
      for (int i = 0; i < 1024; i++) mem[i] <= 32'hBAD0_0000 + 32'(i);
      mem_filled <= 1'b1;
    end else begin
      if (ram_ce_a) begin
        if (ram_we_a) begin mem[ram_addr_a[13:4]] <= ram_din_a; ram_qa <= ram_din_a; end
        else ram_qa <= mem[ram_addr_a[13:4]];
      end
      if (ram_ce_b) begin
        if (ram_we_b) begin mem[ram_addr_b[13:4]] <= ram_din_b; ram_qb <= ram_din_b; end
        else ram_qb <= mem[ram_addr_b[13:4]];
      end
      if (poke_en) mem[0] <= poke_val;
    end
  end

  typedef struct packed {
    logic [31:0] r1;
    logic [31:0] r2;
    logic [31:0] cyc;
  } exp_t;

  exp_t        sb [$];
  logic [31:0] model [32];
  int          checks = 0;
  int          failures = 0;
  logic [31:0] cyc = '0;
  logic        s_rd_fire, s_wr_fire, s_we_a, s_we_b, s_ce_a, s_ce_b;
  logic        s_init_done, s_rd_ready, s_wr_ready, s_rsp_valid;
  logic [13:0] s_addr_a, s_addr_b;
  logic [31:0] s_rs1, s_rs2;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s observed=%h expected=%h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic logic [13:0] exp_addr(input int idx);
    return (14'(idx) << 4) | 14'h3;
  endfunction

  // One clock: score any response, snapshot outputs, account accepted transactions.
  task automatic step();
    exp_t e;
    @(negedge Clock);
    cyc++;
    if (rsp_valid) begin
      if (sb.size() == 0) chk("unexpected_rsp", 64'd1, 64'd0);
      else begin
        e = sb.pop_front();
        chk("rsp_cycle", 64'(cyc), 64'(e.cyc));
        chk("rs1_data", 64'(rs1_data), 64'(e.r1));
        chk("rs2_data", 64'(rs2_data), 64'(e.r2));
      end
    end
    s_rd_fire = rd_valid && rd_ready;
    s_wr_fire = wr_valid && wr_ready;
    s_we_a = ram_we_a; s_we_b = ram_we_b; s_ce_a = ram_ce_a; s_ce_b = ram_ce_b;
    s_addr_a = ram_addr_a; s_addr_b = ram_addr_b;
    s_init_done = init_done; s_rd_ready = rd_ready; s_wr_ready = wr_ready;
    s_rsp_valid = rsp_valid; s_rs1 = rs1_data; s_rs2 = rs2_data;
    if (s_rd_fire) sb.push_back('{model[rs1_idx], model[rs2_idx], cyc + 32'd2});
    if (s_wr_fire && wr_idx != 5'd0) model[wr_idx] = wr_data;
    @(posedge Clock);
    #1;
  endtask

  task automatic do_write(input logic [4:0] idx, input logic [31:0] data);
    logic done = 1'b0;
    wr_valid = 1'b1; wr_idx = idx; wr_data = data;
    for (int i = 0; i < 20 && !done; i++) begin
      step();
      done = s_wr_fire;
    end
    chk("wr_accept", 64'(done), 64'd1);
    wr_valid = 1'b0;
  endtask

  task automatic do_read(input logic [4:0] a, input logic [4:0] b);
    logic done = 1'b0;
    rd_valid = 1'b1; rs1_idx = a; rs2_idx = b;
    for (int i = 0; i < 20 && !done; i++) begin
      step();
      done = s_rd_fire;
    end
    chk("rd_accept", 64'(done), 64'd1);
    rd_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic run_init(input string tag);
    for (int i = 0; i < 16; i++) begin
      step();
      chk({tag, "_we"}, 64'({s_we_a, s_we_b, s_ce_a, s_ce_b}), 64'hF);
      chk({tag, "_addr_a"}, 64'(s_addr_a), 64'(exp_addr(2 * i)));
      chk({tag, "_addr_b"}, 64'(s_addr_b), 64'(exp_addr(2 * i + 1)));
      chk({tag, "_busy"}, 64'({s_init_done, s_rd_ready, s_wr_ready}), 64'd0);
    end
    step();
    chk({tag, "_done"}, 64'({s_init_done, s_we_a, s_we_b}), 64'b100);
  endtask

  initial begin
    Reset = 1'b1; rd_valid = 1'b0; wr_valid = 1'b0;
    rs1_idx = '0; rs2_idx = '0; wr_idx = '0; wr_data = '0;
    for (int i = 0; i < 32; i++) model[i] = '0;
    #1;
    idle(3);
    chk("rst_ctrl", 64'({s_init_done, s_rd_ready, s_wr_ready, s_rsp_valid}), 64'd0);
    chk("rst_ram", 64'({s_we_a, s_we_b, s_ce_a, s_ce_b}), 64'd0);
    chk("rst_data", {s_rs1, s_rs2}, 64'd0);
    Reset = 1'b0;
    run_init("init");
    do_read(5'd5, 5'd31);
    idle(3);

    do_write(5'd7, 32'hDEADBEEF);
    do_read(5'd7, 5'd0);
    idle(3);

    poke_en = 1'b1; poke_val = 32'hFFFF_FFFF;
    step();
    poke_en = 1'b0;
    do_write(5'd0, 32'h12345678);
    chk("x0_no_ram", 64'({s_we_a, s_ce_a, s_we_b, s_ce_b}), 64'd0);
    do_read(5'd0, 5'd0);
    idle(3);

    wr_valid = 1'b1; wr_idx = 5'd3; wr_data = 32'hA5A5A5A5;
    rd_valid = 1'b1; rs1_idx = 5'd3; rs2_idx = 5'd3;
    step();
    chk("arb_first", 64'({s_wr_fire, s_rd_fire}), 64'b10);
    wr_idx = 5'd9; wr_data = 32'h0F0F0F0F;
    step();
    chk("arb_second", 64'({s_wr_fire, s_rd_fire}), 64'b01);
    rd_valid = 1'b0;
    step();
    chk("arb_third", 64'({s_wr_fire, s_rd_fire}), 64'b10);
    wr_valid = 1'b0;
    idle(3);

    for (int n = 1; n <= 8; n++) do_write(5'(n), 32'(n));
    rd_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      rs1_idx = 5'(2 * k + 1); rs2_idx = 5'(2 * k + 2);
      step();
      chk("b2b_accept", 64'(s_rd_fire), 64'd1);
    end
    rd_valid = 1'b0;
    idle(4);
    chk("b2b_drained", 64'(sb.size()), 64'd0);

    do_read(5'd7, 5'd7);
    Reset = 1'b1;
    sb.delete();
    for (int i = 0; i < 32; i++) model[i] = '0;
    idle(2);
    chk("rst_no_rsp", 64'(s_rsp_valid), 64'd0);
    Reset = 1'b0;
    run_init("reinit");
    do_read(5'd7, 5'd7);
    idle(4);
    chk("end_drained", 64'(sb.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
